// File: rtl/glitchless_burst_ctrl_pkg.sv
// Shared types for the glitchless burst controller.
// The state encoding is output-encoded: rd, ds, busy and err are bits of the
// state register itself, so every strobe comes straight off a flip-flop.
// Optional feature macro used by the block: GLITCHLESS_TIMEOUT_EN.
package glitchless_pkg;

  // Bit positions of the strobes inside the state vector.
  localparam int RD_BIT   = 1;
  localparam int DS_BIT   = 2;
  localparam int BUSY_BIT = 3;
  localparam int ERR_BIT  = 4;

  // {err, busy, ds, rd, tag}; tag only separates READ from DLY.
  typedef enum logic [4:0] {
    S_IDLE = 5'b00000,
    S_READ = 5'b01010,
    S_DLY  = 5'b01011,
    S_DONE = 5'b01100,
    S_ERR  = 5'b11000
  } state_e;

  // Width of a counter holding 0..max_ws (never narrower than one bit).
  function automatic int wait_cnt_w(input int max_ws);
    if (max_ws > 0) begin
      return $clog2(max_ws + 1);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/glitchless_burst_ctrl_ws_timer.sv
// Wait-state retry counter: clear, saturating increment and a registered
// at_max flag. Only instantiated when GLITCHLESS_TIMEOUT_EN is defined.
module glitchless_ws_timer
  import glitchless_pkg::*;
#(
  parameter int MAX_WS = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam int                CNT_W = wait_cnt_w(MAX_WS);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WS);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             at_max_q;
  logic             at_max_d;

  // Next count: clear wins, increment saturates at MAX_WS (never wraps).
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = ZERO_C;
    end else if (inc_i && (count_q != MAX_C)) begin
      count_d = count_q + ONE_C;
    end else begin
      count_d = count_q;
    end
    at_max_d = (count_d == MAX_C);
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= ZERO_C;
      at_max_q <= (MAX_C == ZERO_C);
    end else begin
      count_q  <= count_d;
      at_max_q <= at_max_d;
    end
  end

  assign at_max_o = at_max_q;

endmodule

// File: rtl/glitchless_burst_ctrl.sv
// Burst read controller with wait-state retries and glitch-free strobes.
// rd/ds/busy/err are state bits of an output-encoded FSM.
// Macro GLITCHLESS_TIMEOUT_EN: when defined, a retry limit of MAX_WS per beat
// is enforced and a timeout aborts the burst with a one-cycle err pulse;
// when undefined, retries are unlimited and err is tied low.
module glitchless_burst_ctrl
  import glitchless_pkg::*;
#(
  parameter int BEAT_W = 4,
  parameter int MAX_WS = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic              ws,
  input  logic [BEAT_W-1:0] burst_len,
  output logic              rd,
  output logic              ds,
  output logic              busy,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              err
);

  localparam logic [BEAT_W-1:0] ONE_BEAT  = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] ZERO_BEAT = {BEAT_W{1'b0}};

  state_e            state_q;
  logic [BEAT_W-1:0] beat_idx_q;
  logic [BEAT_W-1:0] len_q;
  logic              last_beat_s;

  // The beat just completed is the final one of the latched burst.
  always_comb begin
    last_beat_s = (beat_idx_q == (len_q - ONE_BEAT));
  end

`ifdef GLITCHLESS_TIMEOUT_EN
  logic ws_clr_s;
  logic ws_inc_s;
  logic ws_at_max_s;

  // Retry counter control: clear at burst start and between beats,
  // count every wait-state seen while below the limit.
  always_comb begin
    ws_clr_s = 1'b0;
    ws_inc_s = 1'b0;
    case (state_q)
      S_IDLE:  ws_clr_s = go;
      S_DLY:   ws_inc_s = ws & ~ws_at_max_s;
      S_DONE:  ws_clr_s = ~last_beat_s;
      default: begin
        ws_clr_s = 1'b0;
        ws_inc_s = 1'b0;
      end
    endcase
  end

  glitchless_ws_timer #(
    .MAX_WS (MAX_WS)
  ) u_ws_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (ws_clr_s),
    .inc_i    (ws_inc_s),
    .at_max_o (ws_at_max_s)
  );
`else
  // Without the timeout there is no retry limit to compare against.
  localparam int max_ws_unused = MAX_WS;
`endif

  // Burst sequencing: state (which carries the strobes), beat index, length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      beat_idx_q <= ZERO_BEAT;
      len_q      <= ZERO_BEAT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            state_q    <= S_READ;
            beat_idx_q <= ZERO_BEAT;
            // A zero-length request is served as a single beat.
            len_q      <= (burst_len == ZERO_BEAT) ? ONE_BEAT : burst_len;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_READ: begin
          state_q <= S_DLY;
        end
        S_DLY: begin
          if (!ws) begin
            state_q <= S_DONE;
          end else begin
`ifdef GLITCHLESS_TIMEOUT_EN
            state_q <= ws_at_max_s ? S_ERR : S_READ;
`else
            state_q <= S_READ;
`endif
          end
        end
        S_DONE: begin
          if (last_beat_s) begin
            state_q <= S_IDLE;
          end else begin
            state_q    <= S_READ;
            beat_idx_q <= beat_idx_q + ONE_BEAT;
          end
        end
`ifdef GLITCHLESS_TIMEOUT_EN
        S_ERR: begin
          state_q <= S_IDLE;
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd       = state_q[RD_BIT];
  assign ds       = state_q[DS_BIT];
  assign busy     = state_q[BUSY_BIT];
  assign beat_idx = beat_idx_q;

`ifdef GLITCHLESS_TIMEOUT_EN
  assign err = state_q[ERR_BIT];
`else
  // The ERR state is unreachable here; its bit is kept only for the encoding.
  logic err_bit_unused;
  assign err_bit_unused = state_q[ERR_BIT];
  assign err            = 1'b0;
`endif

endmodule

// File: doc/glitchless_burst_ctrl.md
GLITCHLESS_BURST_CTRL -- requirements
Module: glitchless_burst_ctrl

Interface
REQ-001 Parameter BEAT_W, default 4, width of burst length and beat index (burst of 1..2^BEAT_W-1 beats).
REQ-002 Parameter MAX_WS, default 3, maximum wait-state retries per beat before timeout.
REQ-003 clk  input  1  single clock, all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 go  input  1  burst request, sampled only in IDLE.
REQ-006 ws  input  1  wait-state from memory, sampled only in DLY.
REQ-007 burst_len  input  BEAT_W  beats requested, latched when go accepted.
REQ-008 rd  output  1  read strobe, high in READ and DLY.
REQ-009 ds  output  1  data-strobe, one-cycle pulse per completed beat.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 beat_idx  output  BEAT_W  index of current beat, 0-based.
REQ-012 err  output  1  one-cycle timeout pulse (GLITCHLESS_TIMEOUT_EN only, else tied 0).

Function
REQ-013 rd, ds, busy, err SHALL be driven directly from flip-flops (state bits or registered outputs); no combinational decode on any output path.
REQ-014 States: IDLE, READ, DLY, DONE, ERR.
REQ-015 IDLE: go=1 -> READ, latch burst_len (0 treated as 1), beat_idx<=0, wait count<=0; go=0 -> stay.
REQ-016 READ -> DLY unconditionally.
REQ-017 DLY: ws=0 -> DONE; ws=1 and wait count<MAX_WS -> READ, wait count+1; ws=1 and wait count==MAX_WS -> ERR (timeout enabled) or READ with count saturated (disabled).
REQ-018 DONE: ds=1 for exactly this cycle; if beat_idx==latched_len-1 -> IDLE, else beat_idx+1, wait count<=0, -> READ.
REQ-019 ERR: err=1 one cycle, rd=0, -> IDLE unconditionally; burst abandoned.
REQ-020 go asserted while busy SHALL be ignored; burst_len changes while busy SHALL not affect the active burst.
REQ-021 Latency: go sampled at edge N -> rd high from edge N to edge N+2 minimum; first ds earliest at edge N+2 (high N+2..N+3).
REQ-022 go held high across a burst end SHALL start a new burst one cycle after return to IDLE (IDLE always occupies >=1 cycle).
REQ-023 Wait count width SHALL be $clog2(MAX_WS+1); no wrap-around.

Reset
REQ-024 reset_n low SHALL immediately force IDLE, rd=0, ds=0, busy=0, err=0, beat_idx=0, wait count=0, latched length=0.
REQ-025 Reset mid-burst SHALL abort with no ds or err pulse; release resumes in IDLE.

Configuration
REQ-026 Macro GLITCHLESS_TIMEOUT_EN defined: wait counter, ERR state and err output implemented per REQ-017/019.
REQ-027 Macro undefined: no ERR state, unlimited retries, err constant 0, port still present.

Structure
REQ-028 Package glitchless_pkg SHALL hold the state typedef enum (output-encoded so rd/ds/busy/err are state bits) and the IDLE/READ/DLY/DONE/ERR encodings.
REQ-029 One sub-module glitchless_ws_timer: wait-state counter with clear, increment and at_max flag, instantiated only under GLITCHLESS_TIMEOUT_EN.

Verification
REQ-030 burst_len=1, go pulse, ws=0 -> rd high 2 cycles, ds one pulse, busy low after 3 cycles, beat_idx=0.
REQ-031 burst_len=3, ws=0 throughout -> 3 ds pulses 3 cycles apart, beat_idx 0,1,2, then IDLE.
REQ-032 burst_len=2, ws=1 for 2 DLY samples on beat 0 -> rd high 6 cycles before first ds, then beat 1 with no waits.
REQ-033 GLITCHLESS_TIMEOUT_EN, MAX_WS=3, ws stuck 1 -> err one pulse after 4th DLY, no ds, IDLE next cycle; without macro -> rd stays high, no err.
REQ-034 reset_n low mid-DLY of beat 1 of burst_len=4 -> all outputs 0 immediately, no ds; go after release starts fresh burst at beat_idx=0.
REQ-035 go held high continuously with burst_len=1 -> bursts separated by exactly one IDLE cycle; go toggling while busy has no effect; outputs checked glitch-free at half-cycle sample points.
